// File: rtl/eq_scoreboard.sv
// Expected/actual data scoreboard: buffers expected values in a 4-deep FIFO and
// classifies each actual value as match, mismatch or unknown over a run of N_CHECKS comparisons.
module eq_scoreboard #(
    parameter int W        = 4,
    parameter int N_CHECKS = 16,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             exp_valid,
    input  logic [W-1:0]     exp_data,
    output logic             exp_ready,
    input  logic             act_valid,
    input  logic [W-1:0]     act_data,
    output logic             act_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] mism_cnt,
    output logic [CNT_W-1:0] unk_cnt,
    output logic [CNT_W-1:0] fail_idx,
    output logic [W-1:0]     fail_exp,
    output logic [W-1:0]     fail_act
);

    localparam int DEPTH = 4;
    localparam int IDX_W = 8;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       mem_q [DEPTH];
    logic [1:0]         wr_ptr_q, wr_ptr_d;
    logic [1:0]         rd_ptr_q, rd_ptr_d;
    logic [2:0]         count_q, count_d;
    logic [IDX_W-1:0]   cmp_idx_q, cmp_idx_d;
    logic [CNT_W-1:0]   match_q, match_d;
    logic [CNT_W-1:0]   mism_q, mism_d;
    logic [CNT_W-1:0]   unk_q, unk_d;
    logic [CNT_W-1:0]   fail_idx_q, fail_idx_d;
    logic [W-1:0]       fail_exp_q, fail_exp_d;
    logic [W-1:0]       fail_act_q, fail_act_d;
    logic               fail_seen_q, fail_seen_d;

    logic               in_run, full, empty, push, pop;
    logic               start_ok, last_cmp, is_unk, is_match;
    logic [W-1:0]       head;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    assign in_run    = (state_q == RUN);
    assign full      = (count_q == 3'(DEPTH));
    assign empty     = (count_q == 3'd0);
    assign exp_ready = in_run && !full;
    assign act_ready = in_run && !empty;
    assign push      = exp_valid && exp_ready;
    assign pop       = act_valid && act_ready;
    assign head      = mem_q[rd_ptr_q];
    assign start_ok  = start && !in_run;
    assign last_cmp  = pop && (cmp_idx_q == IDX_W'(N_CHECKS - 1));

    // X/Z detection only has meaning in a 4-state simulator; in hardware it is constant false.
    assign is_unk    = $isunknown(act_data);
    assign is_match  = !is_unk && (act_data === head);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_cmp) state_d = DONE;
            DONE:    if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        cmp_idx_d   = cmp_idx_q;
        match_d     = match_q;
        mism_d      = mism_q;
        unk_d       = unk_q;
        fail_idx_d  = fail_idx_q;
        fail_exp_d  = fail_exp_q;
        fail_act_d  = fail_act_q;
        fail_seen_d = fail_seen_q;

        if (start_ok) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            cmp_idx_d   = '0;
            match_d     = '0;
            mism_d      = '0;
            unk_d       = '0;
            fail_idx_d  = '1;
            fail_exp_d  = '0;
            fail_act_d  = '0;
            fail_seen_d = 1'b0;
        end else if (in_run) begin
            if (push) wr_ptr_d = wr_ptr_q + 2'd1;
            if (pop)  rd_ptr_d = rd_ptr_q + 2'd1;
            count_d = count_q + 3'(push) - 3'(pop);

            if (pop) begin
                cmp_idx_d = cmp_idx_q + 1'b1;
                if (is_unk)        unk_d   = sat_inc(unk_q);
                else if (is_match) match_d = sat_inc(match_q);
                else               mism_d  = sat_inc(mism_q);

                if (!is_match && !fail_seen_q) begin
                    fail_seen_d = 1'b1;
                    fail_idx_d  = CNT_W'(cmp_idx_q);
                    fail_exp_d  = head;
                    fail_act_d  = act_data;
                end
            end

            // Leftover expected values are dropped when the run completes.
            if (last_cmp) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmp_idx_q   <= '0;
            match_q     <= '0;
            mism_q      <= '0;
            unk_q       <= '0;
            fail_idx_q  <= '1;
            fail_exp_q  <= '0;
            fail_act_q  <= '0;
            fail_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cmp_idx_q   <= cmp_idx_d;
            match_q     <= match_d;
            mism_q      <= mism_d;
            unk_q       <= unk_d;
            fail_idx_q  <= fail_idx_d;
            fail_exp_q  <= fail_exp_d;
            fail_act_q  <= fail_act_d;
            fail_seen_q <= fail_seen_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written in the current run.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= exp_data;
    end

    assign busy      = in_run;
    assign done      = (state_q == DONE);
    assign pass      = done && (mism_q == '0) && (unk_q == '0);
    assign match_cnt = match_q;
    assign mism_cnt  = mism_q;
    assign unk_cnt   = unk_q;
    assign fail_idx  = fail_idx_q;
    assign fail_exp  = fail_exp_q;
    assign fail_act  = fail_act_q;

endmodule

// File: tb/tb_eq_scoreboard.sv
// Directed bench for eq_scoreboard with W=4, N_CHECKS=4, CNT_W=8.
module tb_eq_scoreboard;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       exp_valid = 1'b0;
    logic [3:0] exp_data = 4'd0;
    logic       exp_ready;
    logic       act_valid = 1'b0;
    logic [3:0] act_data = 4'd0;
    logic       act_ready;
    logic       busy, done, pass;
    logic [7:0] match_cnt, mism_cnt, unk_cnt, fail_idx;
    logic [3:0] fail_exp, fail_act;

    int tests = 0;
    int fails = 0;

    eq_scoreboard #(.W(4), .N_CHECKS(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .exp_valid (exp_valid),
        .exp_data  (exp_data),
        .exp_ready (exp_ready),
        .act_valid (act_valid),
        .act_data  (act_data),
        .act_ready (act_ready),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .match_cnt (match_cnt),
        .mism_cnt  (mism_cnt),
        .unk_cnt   (unk_cnt),
        .fail_idx  (fail_idx),
        .fail_exp  (fail_exp),
        .fail_act  (fail_act)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic go;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push(input logic [3:0] d);
        exp_valid = 1'b1;
        exp_data  = d;
        tick();
        exp_valid = 1'b0;
    endtask

    task automatic pop(input logic [3:0] d);
        act_valid = 1'b1;
        act_data  = d;
        tick();
        act_valid = 1'b0;
    endtask

    task automatic pair(input logic [3:0] e, input logic [3:0] a);
        push(e);
        pop(a);
    endtask

    logic [3:0] xv;
    int         x_unk, x_match, x_mism;

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_exp_ready", exp_ready, 0);
        chk("rst_act_ready", act_ready, 0);
        chk("rst_match", match_cnt, 0);
        chk("rst_fail_idx", fail_idx, 32'hFF);
        chk("rst_fail_exp", fail_exp, 0);
        rst = 1'b0;
        tick();

        // All-match run
        go();
        $display("[TB] start run 1");
        chk("r1_busy", busy, 1);
        chk("r1_exp_ready", exp_ready, 1);
        chk("r1_act_ready_empty", act_ready, 0);
        pair(4'b0101, 4'b0101);
        chk("r1_match_after1", match_cnt, 1);
        pair(4'b1000, 4'b1000);
        pair(4'b0011, 4'b0011);
        chk("r1_not_done_yet", done, 0);
        pair(4'b1111, 4'b1111);
        $display("[TB] run 1 finished");
        chk("r1_match", match_cnt, 4);
        chk("r1_mism", mism_cnt, 0);
        chk("r1_done", done, 1);
        chk("r1_busy_end", busy, 0);
        chk("r1_pass", pass, 1);
        chk("r1_fail_idx", fail_idx, 32'hFF);

        // Mismatch at the second comparison, and a later one that must not overwrite
        go();
        $display("[TB] start run 2");
        chk("r2_cleared_match", match_cnt, 0);
        chk("r2_done_clear", done, 0);
        pair(4'b0010, 4'b0010);
        pair(4'b1101, 4'b1001);
        chk("r2_mism", mism_cnt, 1);
        chk("r2_fail_idx", fail_idx, 1);
        chk("r2_fail_exp", fail_exp, 4'b1101);
        chk("r2_fail_act", fail_act, 4'b1001);
        pair(4'b0110, 4'b0110);
        pair(4'b0111, 4'b0000);
        chk("r2_mism_final", mism_cnt, 2);
        chk("r2_match_final", match_cnt, 2);
        chk("r2_fail_idx_kept", fail_idx, 1);
        chk("r2_fail_act_kept", fail_act, 4'b1001);
        chk("r2_done", done, 1);
        chk("r2_pass", pass, 0);

        // Unknown bits in the actual value
        go();
        $display("[TB] start run 3");
        xv      = 4'bx001;
        x_unk   = $isunknown(xv) ? 1 : 0;
        x_match = (!$isunknown(xv) && xv === 4'b0001) ? 1 : 0;
        x_mism  = 1 - x_unk - x_match;
        push(4'b0001);
        pop(xv);
        chk("r3_unk", unk_cnt, x_unk);
        chk("r3_match", match_cnt, x_match);
        chk("r3_mism", mism_cnt, x_mism);
        chk("r3_fail_idx", fail_idx, (x_match == 1) ? 32'hFF : 32'h0);
        chk("r3_fail_act", fail_act, (x_match == 1) ? 32'h0 : {28'd0, xv});
        pair(4'b1010, 4'b1010);
        pair(4'b1011, 4'b1011);
        pair(4'b1100, 4'b1100);
        chk("r3_match_final", match_cnt, x_match + 3);
        chk("r3_pass", pass, (x_match == 1) ? 1 : 0);

        // FIFO full behaviour
        go();
        $display("[TB] start run 4");
        for (int i = 0; i < 5; i++) begin
            exp_valid = 1'b1;
            exp_data  = 4'(i);
            chk($sformatf("r4_exp_ready_%0d", i), exp_ready, (i < 4) ? 1 : 0);
            tick();
        end
        exp_valid = 1'b1;
        exp_data  = 4'hA;
        act_valid = 1'b1;
        act_data  = 4'h0;
        chk("r4_full_no_push", exp_ready, 0);
        chk("r4_full_act_ready", act_ready, 1);
        tick();
        chk("r4_pop_match", match_cnt, 1);
        chk("r4_ready_after_pop", exp_ready, 1);
        act_data = 4'h1;
        tick();
        chk("r4_pushpop_match", match_cnt, 2);
        chk("r4_pushpop_ready", exp_ready, 1);
        act_valid = 1'b0;
        exp_data  = 4'hB;
        tick();
        exp_valid = 1'b0;
        chk("r4_full_again", exp_ready, 0);
        pop(4'h2);
        pop(4'h3);
        chk("r4_match_final", match_cnt, 4);
        chk("r4_pass", pass, 1);

        // Leftover entries discarded; reset mid-run
        go();
        $display("[TB] start run 5");
        chk("r5_fifo_discarded", act_ready, 0);
        pair(4'h1, 4'h1);
        pair(4'h2, 4'h3);
        chk("r5_mism_pre", mism_cnt, 1);
        chk("r5_fail_idx_pre", fail_idx, 1);
        rst = 1'b1;
        #1;
        $display("[TB] reset mid-run");
        chk("r5_rst_busy", busy, 0);
        chk("r5_rst_match", match_cnt, 0);
        chk("r5_rst_mism", mism_cnt, 0);
        chk("r5_rst_fail_idx", fail_idx, 32'hFF);
        chk("r5_rst_fail_exp", fail_exp, 0);
        chk("r5_rst_fail_act", fail_act, 0);
        chk("r5_rst_exp_ready", exp_ready, 0);
        chk("r5_rst_done", done, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("r5_idle_busy", busy, 0);

        // Clean run after reset, with start pulsed while running
        go();
        $display("[TB] start run 6");
        chk("r6_busy", busy, 1);
        chk("r6_act_ready", act_ready, 0);
        pair(4'h4, 4'h4);
        chk("r6_match1", match_cnt, 1);
        go();
        chk("r6_start_ignored_match", match_cnt, 1);
        chk("r6_start_ignored_busy", busy, 1);
        pair(4'h5, 4'h5);
        pair(4'h6, 4'h6);
        pair(4'h7, 4'h7);
        chk("r6_match_final", match_cnt, 4);
        chk("r6_done", done, 1);
        chk("r6_pass", pass, 1);
        chk("r6_fail_idx", fail_idx, 32'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
